// File: rtl/clk_div_checker_pkg.sv
// Shared definitions for the divided-clock checker: FSM state encoding and stuck-clock timeout multiplier.
package clk_div_checker_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_CHECK   = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Stuck timeout is this many DIV multiples of half-cycles without a rising edge.
  localparam int STUCK_MULT = 4;

endpackage

// File: rtl/clk_div_checker_sampler.sv
// Samples div_clk on both clk edges; each sample carries a valid bit that is cleared by reset.
module dual_edge_sampler (
  input  logic clk,
  input  logic rst,
  input  logic div_clk,
  output logic smp_old,
  output logic smp_new,
  output logic vld_old,
  output logic vld_new
);

  // posedge sample (older of the pair seen at the next posedge)
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_old <= 1'b0;
      vld_old <= 1'b0;
    end else begin
      smp_old <= div_clk;
      vld_old <= 1'b1;
    end
  end

  // negedge sample (newer of the pair)
  always_ff @(negedge clk) begin
    if (!rst) begin
      smp_new <= 1'b0;
      vld_new <= 1'b0;
    end else begin
      smp_new <= div_clk;
      vld_new <= 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_checker.sv
// Measures div_clk period/high time at half-cycle resolution and checks it against the expected divide ratio.
module clk_div_checker
  import clk_div_checker_pkg::*;
#(
  parameter int DIV      = 3,
  parameter int CW       = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_clk,
  input  logic          err_clr,
  output logic [CW-1:0] period_hc,
  output logic [CW-1:0] high_hc,
  output logic          meas_valid,
  output logic          locked,
  output logic          err
);

  localparam int GW        = $clog2(LOCK_CNT + 1);
  localparam int CMAX      = (2 ** CW) - 1;
  localparam int STUCK_RAW = STUCK_MULT * DIV;
  localparam logic [CW-1:0] PER_EXP  = CW'(2 * DIV);
  localparam logic [CW-1:0] HI_EXP   = CW'(DIV);
  localparam logic [CW-1:0] STUCK_HC = CW'((STUCK_RAW > CMAX) ? CMAX : STUCK_RAW);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [GW-1:0] sat_inc_good(input logic [GW-1:0] v);
    return (v == {GW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic sp_p0, sn_p0, sp_vld_p0, sn_vld_p0;

  dual_edge_sampler u_sampler (
    .clk     (clk),
    .rst     (rst),
    .div_clk (div_clk),
    .smp_old (sp_p0),
    .smp_new (sn_p0),
    .vld_old (sp_vld_p0),
    .vld_new (sn_vld_p0)
  );

  state_e        state_q, state_n;
  logic [CW-1:0] pc_q, hc_q, pc_n, hc_n, per_n, hi_n;
  logic [GW-1:0] good_q, good_n;
  logic          last_p1, last_vld_p1;
  logic [2:0]    smp3, vld3;
  logic          trk, close, stuck, ok, rise, fall, in_spec, set_err;

  // p0 -> p1: walk the two half-cycle samples in age order against the previous newest sample
  always_comb begin
    smp3  = {sn_p0, sp_p0, last_p1};
    vld3  = {sn_vld_p0, sp_vld_p0, last_vld_p1};
    trk   = (state_q != ST_ACQUIRE);
    pc_n  = pc_q;
    hc_n  = hc_q;
    per_n = '0;
    hi_n  = '0;
    close = 1'b0;
    stuck = 1'b0;
    ok    = 1'b0;
    rise  = 1'b0;
    fall  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ok   = vld3[i] & vld3[i+1];
      rise = ok & ~smp3[i] & smp3[i+1];
      fall = ok & smp3[i] & ~smp3[i+1];
      if (!trk) begin
        if (rise) begin
          trk  = 1'b1;
          pc_n = '0;
          hc_n = '0;
        end
      end else begin
        pc_n = sat_inc(pc_n);
        if (fall) hc_n = pc_n;
        if (rise) begin
          close = 1'b1;
          per_n = pc_n;
          hi_n  = hc_n;
          pc_n  = '0;
          hc_n  = '0;
        end else if (pc_n >= STUCK_HC) begin
          stuck = 1'b1;
          trk   = 1'b0;
          pc_n  = '0;
          hc_n  = '0;
        end
      end
    end
  end

  always_comb begin
    state_n = state_q;
    good_n  = good_q;
    set_err = 1'b0;
    in_spec = (per_n == PER_EXP) && (hi_n == HI_EXP);
    if (stuck) begin
      set_err = 1'b1;
      good_n  = '0;
      state_n = trk ? ST_CHECK : ST_ACQUIRE;
    end else if (close) begin
      if (!in_spec) begin
        set_err = 1'b1;
        good_n  = '0;
        state_n = ST_CHECK;
      end else if (state_q == ST_CHECK) begin
        good_n = sat_inc_good(good_q);
        if (int'(good_n) >= LOCK_CNT) state_n = ST_LOCKED;
      end
    end else if (state_q == ST_ACQUIRE && trk) begin
      state_n = ST_CHECK;
    end
  end

  // p1: state, counters and published measurement
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_ACQUIRE;
      pc_q        <= '0;
      hc_q        <= '0;
      good_q      <= '0;
      last_p1     <= 1'b0;
      last_vld_p1 <= 1'b0;
      period_hc   <= '0;
      high_hc     <= '0;
      meas_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      hc_q        <= hc_n;
      good_q      <= good_n;
      last_p1     <= sn_p0;
      last_vld_p1 <= sn_vld_p0;
      meas_valid  <= close;
      if (close) begin
        period_hc <= per_n;
        high_hc   <= hi_n;
      end
      err <= (err & ~err_clr) | set_err;
    end
  end

  assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clk_div_checker.sv
// Bench for clk_div_checker: directed scenarios plus random waveforms against an edge-index reference model.
module tb_clk_div_checker;

  localparam int DIV = 3, CW = 8, LOCK_CNT = 4;

  logic clk = 1'b0, rst = 1'b0, div_clk = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] period_hc, high_hc;
  logic meas_valid, locked, err;

  clk_div_checker #(.DIV(DIV), .CW(CW), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .err_clr(err_clr),
    .period_hc(period_hc), .high_hc(high_hc), .meas_valid(meas_valid),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int npos = 0;
  bit rst_want = 1'b0, clr_req = 1'b0;

  // Reference model: works on the index of each driven half-cycle value.
  typedef struct {int t; int per; int hi;} exp_t;
  exp_t q[$];
  int set_t[$], clr_t[$], lk_t[$];
  bit lk_v[$];
  bit m_prev, m_prev_vld, m_trk;
  int m_idx = 0, m_rise = 0, m_fall = -1, m_good = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit err_at(input int t);
    int ls = -1, lc = -1;
    foreach (set_t[i]) if (set_t[i] <= t && set_t[i] > ls) ls = set_t[i];
    foreach (clr_t[i]) if (clr_t[i] <= t && clr_t[i] > lc) lc = clr_t[i];
    return (ls >= 0) && (ls >= lc);
  endfunction

  function automatic bit lock_at(input int t);
    bit r = 1'b0;
    foreach (lk_t[i]) if (lk_t[i] <= t) r = lk_v[i];
    return r;
  endfunction

  task automatic model_reset();
    q.delete(); set_t.delete(); clr_t.delete(); lk_t.delete(); lk_v.delete();
    m_prev_vld = 1'b0; m_trk = 1'b0; m_good = 0;
  endtask

  task automatic model_step(input bit v, input int t);
    bit rise, fall;
    exp_t e;
    if (m_prev_vld) begin
      rise = !m_prev && v;
      fall = m_prev && !v;
      if (!m_trk) begin
        if (rise) begin m_trk = 1'b1; m_rise = m_idx; m_fall = -1; end
      end else begin
        if (fall) m_fall = m_idx;
        if (rise) begin
          e.t = t; e.per = m_idx - m_rise; e.hi = m_fall - m_rise;
          q.push_back(e);
          if (e.per == 2 * DIV && e.hi == DIV) begin
            m_good++;
            if (m_good == LOCK_CNT) begin lk_t.push_back(t); lk_v.push_back(1'b1); end
          end else begin
            m_good = 0;
            set_t.push_back(t);
            lk_t.push_back(t); lk_v.push_back(1'b0);
          end
          m_rise = m_idx; m_fall = -1;
        end else if (m_idx - m_rise >= 4 * DIV) begin
          m_trk = 1'b0; m_good = 0;
          set_t.push_back(t);
          lk_t.push_back(t); lk_v.push_back(1'b0);
        end
      end
    end
    m_prev = v; m_prev_vld = 1'b1; m_idx++;
  endtask

  task automatic monitor();
    if (!rst) begin
      chk("rst_period_hc", int'(period_hc), 0);
      chk("rst_high_hc", int'(high_hc), 0);
      chk("rst_meas_valid", int'(meas_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err), 0);
    end else begin
      if (q.size() > 0 && q[0].t == npos) begin
        chk("meas_valid", int'(meas_valid), 1);
        chk("period_hc", int'(period_hc), q[0].per);
        chk("high_hc", int'(high_hc), q[0].hi);
        void'(q.pop_front());
      end else begin
        chk("meas_idle", int'(meas_valid), 0);
      end
      chk("locked", int'(locked), int'(lock_at(npos)));
      chk("err", int'(err), int'(err_at(npos)));
    end
  endtask

  // One half-cycle: wait for a clk edge, check outputs on posedges, then drive the next value.
  task automatic hc(input bit v);
    bit is_pos;
    @(posedge clk or negedge clk);
    is_pos = clk;
    #1;
    if (is_pos) begin
      npos++;
      monitor();
      rst = rst_want;
      err_clr = clr_req;
      clr_req = 1'b0;
    end
    div_clk = v;
    if (!rst) begin
      model_reset();
    end else begin
      if (is_pos && err_clr) clr_t.push_back(npos + 1);
      model_step(v, is_pos ? npos + 1 : npos + 2);
    end
  endtask

  task automatic wave(input int hi, input int lo);
    repeat (hi) hc(1'b1);
    repeat (lo) hc(1'b0);
  endtask

  initial begin
    int hi, lo;
    rst_want = 1'b0;
    repeat (6) hc(1'b0);

    // Clean divide-by-3, 50% duty: measure and lock
    rst_want = 1'b1;
    repeat (8) wave(3, 3);
    chk("lock_period_hc", int'(period_hc), 6);
    chk("lock_high_hc", int'(high_hc), 3);
    chk("lock_locked", int'(locked), 1);
    chk("lock_err", int'(err), 0);

    // Stuck low after lock
    repeat (16) hc(1'b0);
    chk("stuck_err", int'(err), 1);
    chk("stuck_locked", int'(locked), 0);

    // Posedge-only 1/3 duty
    rst_want = 1'b0;
    repeat (4) hc(1'b0);
    rst_want = 1'b1;
    repeat (6) wave(2, 4);
    chk("duty_period_hc", int'(period_hc), 6);
    chk("duty_high_hc", int'(high_hc), 2);
    chk("duty_err", int'(err), 1);
    chk("duty_locked", int'(locked), 0);

    // Lock, then a one-cycle reset pulse mid-period, then relock
    rst_want = 1'b0;
    repeat (4) hc(1'b0);
    rst_want = 1'b1;
    repeat (6) wave(3, 3);
    chk("relock0_locked", int'(locked), 1);
    hc(1'b1); hc(1'b1);
    rst_want = 1'b0;
    hc(1'b1); hc(1'b0);
    rst_want = 1'b1;
    hc(1'b0); hc(1'b0);
    repeat (6) wave(3, 3);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err", int'(err), 0);

    // Clear coinciding with a bad period keeps err; a later clear with no error drops it
    wave(2, 4);
    clr_req = 1'b1;
    wave(3, 3);
    chk("clr_setwins_err", int'(err), 1);
    clr_req = 1'b1;
    wave(3, 3);
    chk("clr_err", int'(err), 0);

    // Half-cycle glitch pulse is measured and judged out-of-spec
    wave(1, 5);
    wave(3, 3);
    chk("glitch_high_hc", int'(high_hc), 1);
    chk("glitch_err", int'(err), 1);
    chk("glitch_locked", int'(locked), 0);

    // Random waveforms, mostly in-spec, with occasional clears
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 6) begin
        hi = DIV; lo = DIV;
      end else begin
        hi = $urandom_range(1, 5); lo = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 7) == 0) clr_req = 1'b1;
      wave(hi, lo);
    end
    repeat (6) hc(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_checker.md
CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

Interface
REQ-001 Parameter DIV, default 3, meaning expected divide ratio (div_clk period in clk cycles); range 2..63.
REQ-002 Parameter CW, default 8, meaning width of half-cycle counters and measurement outputs.
REQ-003 Parameter LOCK_CNT, default 4, meaning consecutive in-spec periods required to assert locked.
REQ-004 clk  input  1  system clock; the divider's source clock.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 div_clk  input  1  divided clock from the upstream divider; edges aligned to either clk edge.
REQ-007 err_clr  input  1  clears sticky err when high at a clk rising edge.
REQ-008 period_hc  output  CW  last measured div_clk period, in clk half-cycles.
REQ-009 high_hc  output  CW  last measured div_clk high time, in clk half-cycles.
REQ-010 meas_valid  output  1  one-clk pulse; period_hc/high_hc updated this cycle.
REQ-011 locked  output  1  LOCK_CNT consecutive in-spec periods seen, none failed since.
REQ-012 err  output  1  sticky: out-of-spec period or stuck clock detected.

Function
REQ-013 div_clk SHALL be sampled at every clk negedge (sn) and every clk posedge (sp); all other logic SHALL run on clk posedge only.
REQ-014 Each posedge SHALL process two ordered half-cycle samples, sp (older) then sn (newer), against the previous newest sample, giving half-cycle resolution.
REQ-015 A period SHALL be measured between consecutive div_clk rising edges; high time from rising edge to next falling edge.
REQ-016 In-spec SHALL mean period_hc == 2*DIV and high_hc == DIV (exact, no tolerance).
REQ-017 FSM states: ACQUIRE, CHECK, LOCKED.
REQ-018 ACQUIRE: counters idle; first rising edge -> CHECK, counters start; no meas_valid.
REQ-019 CHECK: each completed period pulses meas_valid; in-spec increments good count; at count == LOCK_CNT -> LOCKED, locked=1.
REQ-020 Out-of-spec in CHECK or LOCKED: err=1, good count=0, locked=0, state CHECK.
REQ-021 Stuck clock: no rising edge for 4*DIV half-cycles in CHECK/LOCKED: err=1, locked=0, good count=0, state ACQUIRE, no meas_valid.
REQ-022 meas_valid SHALL assert no later than the 2nd clk posedge after the closing div_clk rising edge.
REQ-023 Counters SHALL saturate at 2^CW-1, never wrap.
REQ-024 err_clr and a new error in the same cycle: err stays 1 (set wins).
REQ-025 Two div_clk edges inside one clk cycle (glitch) SHALL count as a measured period and be judged out-of-spec.

Reset
REQ-026 rst low at a clk posedge: state ACQUIRE; period_hc=0, high_hc=0, meas_valid=0, locked=0, err=0; counters and sp cleared.
REQ-027 rst low at a clk negedge SHALL clear sn.
REQ-028 Reset mid-measurement SHALL discard the partial period; ACQUIRE restarts at the first posedge with rst high.

Structure
REQ-029 Package clk_div_checker_pkg SHALL hold the FSM state enum and the stuck-timeout multiplier (4).
REQ-030 Sub-module dual_edge_sampler SHALL contain the sn/sp flops and output the ordered sample pair.

Verification
REQ-031 Upstream divide-by-3 50% duty, rst released -> first meas_valid period_hc=6, high_hc=3; locked=1 after 4th in-spec period; err=0.
REQ-032 Divide-by-3, posedge-only 1/3 duty -> period_hc=6, high_hc=2, err=1, locked stays 0.
REQ-033 Lock, then hold div_clk low -> err=1, locked=0 within 12 half-cycles of last rising edge, state ACQUIRE, no meas_valid.
REQ-034 Lock, pulse rst low 1 cycle mid-period -> all outputs 0 next posedge; relock after 4 periods.
REQ-035 err=1, err_clr high same cycle as bad period -> err remains 1; err_clr next cycle with no error -> err=0.
